// File: rtl/reflex_round_sequencer.sv
// Reflex game round sequencer: start synchroniser, LOAD/PLAY/RESULT round loop, saturating score.
// Optional REFLEX_SEQ_EARLY_FINISH_EN closes the play window as soon as the mismatch vector is zero.
module reflex_round_sequencer #(
    parameter int PLAY_CYCLES   = 199,
    parameter int RESULT_CYCLES = 10,
    parameter int ROUNDS        = 4,
    parameter int SCORE_W       = 4
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic               start,
    input  logic [7:0]         mismatch,
    output logic               code_load,
    output logic               input_clear,
    output logic               play_active,
    output logic               correct_light,
    output logic               incorrect_light,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         round,
    output logic               game_over
);
    // state  | meaning
    // IDLE   | waiting for first start, all outputs low
    // LOAD   | one cycle: reload code, clear player input
    // PLAY   | play window open, timer runs
    // RESULT | correct/incorrect light shown
    // DONE   | game finished, score/round held
    typedef enum logic [2:0] {IDLE, LOAD, PLAY, RESULT, DONE} state_t;

    localparam int MAX_CYC = (PLAY_CYCLES > RESULT_CYCLES) ? PLAY_CYCLES : RESULT_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);

    state_t             r_state;
    logic [TW-1:0]      r_timer;
    logic               r_sync1, r_sync2, r_sync3, r_start_pulse;
    logic               r_code_load, r_input_clear, r_play_active;
    logic               r_correct, r_incorrect, r_game_over;
    logic [SCORE_W-1:0] r_score;
    logic [2:0]         r_round;

    logic w_hit, w_play_last, w_result_last, w_window_end;

    assign w_hit         = (mismatch == 8'h00);
    assign w_play_last   = (r_timer == TW'(PLAY_CYCLES - 1));
    assign w_result_last = (r_timer == TW'(RESULT_CYCLES - 1));
`ifdef REFLEX_SEQ_EARLY_FINISH_EN
    assign w_window_end  = w_play_last || w_hit;
`else
    assign w_window_end  = w_play_last;
`endif

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_timer       <= '0;
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_sync3       <= 1'b0;
            r_start_pulse <= 1'b0;
            r_code_load   <= 1'b0;
            r_input_clear <= 1'b0;
            r_play_active <= 1'b0;
            r_correct     <= 1'b0;
            r_incorrect   <= 1'b0;
            r_game_over   <= 1'b0;
            r_score       <= '0;
            r_round       <= '0;
        end else begin
            r_sync1       <= start;
            r_sync2       <= r_sync1;
            r_sync3       <= r_sync2;
            r_start_pulse <= r_sync2 & ~r_sync3;
            r_code_load   <= 1'b0;
            r_input_clear <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (r_start_pulse) begin
                        r_state       <= LOAD;
                        r_timer       <= '0;
                        r_score       <= '0;
                        r_round       <= '0;
                        r_game_over   <= 1'b0;
                        r_code_load   <= 1'b1;
                        r_input_clear <= 1'b1;
                    end
                end
                LOAD: begin
                    r_state       <= PLAY;
                    r_timer       <= '0;
                    r_play_active <= 1'b1;
                end
                PLAY: begin
                    if (w_window_end) begin
                        r_state       <= RESULT;
                        r_timer       <= '0;
                        r_play_active <= 1'b0;
                        r_correct     <= w_hit;
                        r_incorrect   <= ~w_hit;
                        r_round       <= r_round + 3'd1;
                        if (w_hit && (r_score != '1))
                            r_score <= r_score + SCORE_W'(1);
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                RESULT: begin
                    if (w_result_last) begin
                        r_timer     <= '0;
                        r_correct   <= 1'b0;
                        r_incorrect <= 1'b0;
                        if (r_round == 3'(ROUNDS)) begin
                            r_state     <= DONE;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state       <= LOAD;
                            r_code_load   <= 1'b1;
                            r_input_clear <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign code_load       = r_code_load;
    assign input_clear     = r_input_clear;
    assign play_active     = r_play_active;
    assign correct_light   = r_correct;
    assign incorrect_light = r_incorrect;
    assign score           = r_score;
    assign round           = r_round;
    assign game_over       = r_game_over;
endmodule

// File: tb/tb_reflex_round_sequencer.sv
// Scoreboard bench for reflex_round_sequencer: driver pushes expected round results,
// a negedge monitor pops and compares at the end of each result display.
`timescale 1ns/1ps
module tb_reflex_round_sequencer;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst_n, start, start2;
    logic [7:0] mismatch;
    logic       code_load, input_clear, play_active, correct_light, incorrect_light, game_over;
    logic [3:0] score;
    logic [2:0] round;
    logic       code_load2, input_clear2, play_active2, correct2, incorrect2, game_over2;
    logic [1:0] score2;
    logic [2:0] round2;

`ifdef REFLEX_SEQ_EARLY_FINISH_EN
    localparam int PL_HIT = 1;
`else
    localparam int PL_HIT = 199;
`endif
    localparam int PL_MISS = 199;

    reflex_round_sequencer u_dut (
        .clock(clock), .rst_n(rst_n), .start(start), .mismatch(mismatch),
        .code_load(code_load), .input_clear(input_clear), .play_active(play_active),
        .correct_light(correct_light), .incorrect_light(incorrect_light),
        .score(score), .round(round), .game_over(game_over)
    );

    reflex_round_sequencer #(.PLAY_CYCLES(3), .RESULT_CYCLES(2), .ROUNDS(5), .SCORE_W(2)) u_sat (
        .clock(clock), .rst_n(rst_n), .start(start2), .mismatch(8'h00),
        .code_load(code_load2), .input_clear(input_clear2), .play_active(play_active2),
        .correct_light(correct2), .incorrect_light(incorrect2),
        .score(score2), .round(round2), .game_over(game_over2)
    );

    typedef struct {
        logic hit;
        int   score;
        int   round;
        int   play_len;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // monitor
    int   play_cnt = 0, last_play = 0, res_cnt = 0, load_w = 0, n_load = 0;
    int   c_score, c_round, c_play;
    logic c_hit, both_seen = 1'b0;
    logic pa_q = 1'b0, light_q = 1'b0, cl_q = 1'b0;

    always @(negedge clock) begin
        logic light;
        exp_t e;
        light = correct_light | incorrect_light;
        if (play_active) play_cnt = pa_q ? play_cnt + 1 : 1;
        else if (pa_q) last_play = play_cnt;
        if (correct_light && incorrect_light) both_seen = 1'b1;
        if (light && !light_q) begin
            c_hit     = correct_light;
            c_score   = int'(score);
            c_round   = int'(round);
            c_play    = last_play;
            res_cnt   = 1;
            both_seen = correct_light & incorrect_light;
        end else if (light) begin
            res_cnt++;
        end else if (light_q) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("result_hit", int'(c_hit), int'(e.hit));
                check("result_score", c_score, e.score);
                check("result_round", c_round, e.round);
                check("play_len", c_play, e.play_len);
                check("result_len", res_cnt, 10);
                check("both_lights", int'(both_seen), 0);
            end
        end
        if (code_load) begin
            load_w = cl_q ? load_w + 1 : 1;
            if (!cl_q) n_load++;
            check("clear_with_load", int'(input_clear), 1);
        end else if (cl_q) begin
            check("load_width", load_w, 1);
        end
        pa_q    = play_active;
        light_q = light;
        cl_q    = code_load;
    end

    function automatic int out_vec();
        return int'({code_load, input_clear, play_active, correct_light,
                     incorrect_light, game_over, score, round});
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        repeat (4) @(posedge clock);
        #1 start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic wait_play_rise(input string name);
        logic prev;
        bit   seen;
        prev = play_active;
        seen = 0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(posedge clock); #1;
            if (play_active && !prev) seen = 1;
            prev = play_active;
        end
        if (!seen) check(name, 0, 1);
    endtask

    task automatic wait_light_rise(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(posedge clock); #1;
            if (correct_light || incorrect_light) seen = 1;
        end
        if (!seen) check(name, 0, 1);
    endtask

    task automatic wait_game_over(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge clock); #1;
            if (game_over) seen = 1;
        end
        if (!seen) check(name, 0, 1);
        repeat (2) @(posedge clock);
        #1;
    endtask

    int base;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        start2   = 1'b0;
        mismatch = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", out_vec(), 0);
        check("reset_sat_game_over", int'(game_over2), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // reset in the middle of a play window
        mismatch = 8'h5A;
        pulse_start();
        repeat (45) @(posedge clock);
        @(negedge clock);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", out_vec(), 0);
        @(negedge clock);
        rst_n = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        check("idle_after_reset", out_vec(), 0);

        // all rounds solved
        mismatch = 8'h00;
        for (int k = 1; k <= 4; k++) exp_q.push_back('{1'b1, k, k, PL_HIT});
        base = n_load;
        pulse_start();
        wait_game_over("timeout_game_a");
        check("a_game_over", int'(game_over), 1);
        check("a_score", int'(score), 4);
        check("a_round", int'(round), 4);
        check("a_loads", n_load - base, 4);
        check("a_queue_empty", exp_q.size(), 0);

        // all rounds missed; restart from DONE, start toggled in PLAY and RESULT
        mismatch = 8'h5A;
        for (int k = 1; k <= 4; k++) exp_q.push_back('{1'b0, 0, k, PL_MISS});
        base = n_load;
        pulse_start();
        check("b_score_cleared", int'(score), 0);
        check("b_round_cleared", int'(round), 0);
        check("b_game_over_low", int'(game_over), 0);
        wait_play_rise("timeout_b_play2");
        repeat (10) @(posedge clock);
        #1;
        pulse_start();
        wait_light_rise("timeout_b_light2");
        pulse_start();
        wait_game_over("timeout_game_b");
        check("b_game_over", int'(game_over), 1);
        check("b_score", int'(score), 0);
        check("b_round", int'(round), 4);
        check("b_loads", n_load - base, 4);
        check("b_queue_empty", exp_q.size(), 0);

        // mismatch appears only on the final PLAY cycle of round 2
        mismatch = 8'h00;
`ifdef REFLEX_SEQ_EARLY_FINISH_EN
        for (int k = 1; k <= 4; k++) exp_q.push_back('{1'b1, k, k, PL_HIT});
`else
        exp_q.push_back('{1'b1, 1, 1, PL_MISS});
        exp_q.push_back('{1'b0, 1, 2, PL_MISS});
        exp_q.push_back('{1'b1, 2, 3, PL_MISS});
        exp_q.push_back('{1'b1, 3, 4, PL_MISS});
`endif
        pulse_start();
`ifndef REFLEX_SEQ_EARLY_FINISH_EN
        wait_play_rise("timeout_c_play2");
        repeat (198) @(posedge clock);
        #1 mismatch = 8'h01;
        @(posedge clock);
        #1 mismatch = 8'h00;
`endif
        wait_game_over("timeout_game_c");
`ifdef REFLEX_SEQ_EARLY_FINISH_EN
        check("c_score", int'(score), 4);
`else
        check("c_score", int'(score), 3);
`endif
        check("c_round", int'(round), 4);
        check("c_queue_empty", exp_q.size(), 0);

        // narrow score saturates
        start2 = 1'b1;
        repeat (4) @(posedge clock);
        #1 start2 = 1'b0;
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 500 && !seen; i++) begin
                @(posedge clock); #1;
                if (game_over2) seen = 1;
            end
            check("sat_game_over", int'(seen), 1);
        end
        check("sat_score", int'(score2), 3);
        check("sat_round", int'(round2), 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
